// File: rtl/mcp_bus_pkg.sv
// Shared types and constants for the MCP bus initiator: FSM state encoding,
// default timings, pin idle levels and the phase-length helper.
package mcp_bus_pkg;

    typedef enum logic [2:0] {
        ST_RSTP,
        ST_IDLE,
        ST_SETUP,
        ST_RDS,
        ST_WRS,
        ST_HOLD,
        ST_REC
    } state_e;

    localparam int unsigned CNT_W   = 5;
    localparam int unsigned CNT_MAX = 31;

    localparam int unsigned DEF_AB    = 20;
    localparam int unsigned DEF_W     = 16;
    localparam int unsigned DEF_T_AS  = 1;
    localparam int unsigned DEF_T_RD  = 8;
    localparam int unsigned DEF_T_WP  = 5;
    localparam int unsigned DEF_T_WH  = 1;
    localparam int unsigned DEF_T_REC = 2;
    localparam int unsigned DEF_T_RST = 20;

    // Idle levels of the control pins; strobes and chip enables are active-low
    // except CE2s, and RY_XBY idles high (flash ready).
    localparam logic PIN_OFF_N = 1'b1;
    localparam logic CE2_OFF   = 1'b0;
    localparam logic RY_IDLE   = 1'b1;

    // Final counter value of a phase lasting t cycles. A zero length still
    // costs one cycle; lengths beyond the counter range clip at its ceiling.
    function automatic logic [CNT_W-1:0] phase_last(input int unsigned t);
        if (t <= 1) begin
            return '0;
        end
        if (t > CNT_MAX + 1) begin
            return '1;
        end
        return CNT_W'(t - 1);
    endfunction

endpackage

// File: rtl/mcp_sync2.sv
// Two-flop synchronizer for a single asynchronous level input.
module mcp_sync2
    import mcp_bus_pkg::*;
#(
    parameter logic RST_VAL = RY_IDLE
) (
    input  logic clk,
    input  logic srst,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/mcp_bus_initiator.sv
// Host-side initiator for the MCP flash+SRAM bus: one request at a time, turned
// into chip-enable/strobe sequences timed by a single saturating phase counter.
module mcp_bus_initiator
    import mcp_bus_pkg::*;
#(
    parameter int unsigned AB       = DEF_AB,
    parameter int unsigned W        = DEF_W,
    parameter int unsigned T_AS     = DEF_T_AS,
    parameter int unsigned T_RD     = DEF_T_RD,
    parameter int unsigned T_WP     = DEF_T_WP,
    parameter int unsigned T_WH     = DEF_T_WH,
    parameter int unsigned T_REC    = DEF_T_REC,
    parameter int unsigned T_RST    = DEF_T_RST,
    parameter int unsigned WAIT_RDY = 0
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          REQ_VALID,
    output logic          REQ_READY,
    input  logic          REQ_WR,
    input  logic          REQ_SEL,
    input  logic [AB-1:0] REQ_ADDR,
    input  logic          REQ_SA,
    input  logic [W-1:0]  REQ_WDATA,
    input  logic [1:0]    REQ_BE,
    output logic          RSP_VALID,
    output logic [W-1:0]  RSP_RDATA,
    output logic          FLASH_BUSY,
    output logic [AB-1:0] A,
    output logic          SA,
    output logic [W-1:0]  DQ_O,
    output logic          DQ_OE,
    input  logic [W-1:0]  DQ_I,
    output logic          XCEf,
    output logic          XCE1s,
    output logic          CE2s,
    output logic          XOE,
    output logic          XWE,
    output logic          XLB,
    output logic          XUB,
    output logic          XRESET,
    output logic          XWP,
    output logic          CIOf,
    output logic          CIOs,
    input  logic          RY_XBY
);

    localparam logic [CNT_W-1:0] LAST_AS  = phase_last(T_AS);
    localparam logic [CNT_W-1:0] LAST_RD  = phase_last(T_RD);
    localparam logic [CNT_W-1:0] LAST_WP  = phase_last(T_WP);
    localparam logic [CNT_W-1:0] LAST_WH  = phase_last(T_WH);
    localparam logic [CNT_W-1:0] LAST_REC = phase_last(T_REC);
    localparam logic [CNT_W-1:0] LAST_RST = phase_last(T_RST);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AB-1:0]    addr_q, addr_d;
    logic             sa_q, sa_d;
    logic [W-1:0]     wdata_q, wdata_d;
    logic [W-1:0]     rdata_q, rdata_d;
    logic [1:0]       be_q, be_d;
    logic             sel_q, sel_d;
    logic             wr_q, wr_d;
    logic             nop_q, nop_d;

    logic             ry_sync;
    logic             flash_busy;
    logic             ready;
    logic [CNT_W-1:0] cnt_last;
    logic             phase_done;
    logic             ce_on;

    mcp_sync2 #(.RST_VAL(RY_IDLE)) u_ry_sync (
        .clk  (CLK),
        .srst (RESET),
        .d    (RY_XBY),
        .q    (ry_sync)
    );

    assign flash_busy = ~ry_sync;

    always_comb begin
        cnt_last = '0;
        case (state_q)
            ST_RSTP:  cnt_last = LAST_RST;
            ST_SETUP: cnt_last = LAST_AS;
            ST_RDS:   cnt_last = LAST_RD;
            ST_WRS:   cnt_last = LAST_WP;
            ST_HOLD:  cnt_last = LAST_WH;
            ST_REC:   cnt_last = LAST_REC;
            default:  cnt_last = '0;
        endcase
        phase_done = (cnt_q == cnt_last);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        addr_d  = addr_q;
        sa_d    = sa_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        be_d    = be_q;
        sel_d   = sel_q;
        wr_d    = wr_q;
        nop_d   = nop_q;
        ready   = 1'b0;

        case (state_q)
            ST_RSTP: begin
                if (phase_done) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                ready = !((WAIT_RDY != 32'd0) && !REQ_SEL && flash_busy);
                if (REQ_VALID && ready) begin
                    addr_d  = REQ_ADDR;
                    sa_d    = REQ_SA;
                    wdata_d = REQ_WDATA;
                    be_d    = REQ_BE;
                    sel_d   = REQ_SEL;
                    wr_d    = REQ_WR;
                    // An SRAM write with no byte lanes has nothing to strobe:
                    // complete it straight away without touching the pins.
                    nop_d   = REQ_SEL && REQ_WR && (REQ_BE == 2'b00);
                    state_d = nop_d ? ST_HOLD : ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (phase_done) state_d = wr_q ? ST_WRS : ST_RDS;
            end
            ST_RDS: begin
                if (phase_done) begin
                    rdata_d = DQ_I;
                    state_d = ST_HOLD;
                end
            end
            ST_WRS: begin
                if (phase_done) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (phase_done || nop_q) state_d = ST_REC;
            end
            ST_REC: begin
                if (phase_done) state_d = ST_IDLE;
            end
            default: state_d = ST_RSTP;
        endcase

        if (state_d != state_q) cnt_d = '0;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_RSTP;
            cnt_q   <= '0;
            addr_q  <= '0;
            sa_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            be_q    <= 2'b00;
            sel_q   <= 1'b0;
            wr_q    <= 1'b0;
            nop_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            sa_q    <= sa_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            be_q    <= be_d;
            sel_q   <= sel_d;
            wr_q    <= wr_d;
            nop_q   <= nop_d;
        end
    end

    // Pins are decoded from registered state only, so they change on clock edges.
    always_comb begin
        XCEf      = PIN_OFF_N;
        XCE1s     = PIN_OFF_N;
        CE2s      = CE2_OFF;
        XOE       = PIN_OFF_N;
        XWE       = PIN_OFF_N;
        XLB       = PIN_OFF_N;
        XUB       = PIN_OFF_N;
        XRESET    = PIN_OFF_N;
        DQ_OE     = 1'b0;
        RSP_VALID = 1'b0;

        ce_on = (state_q == ST_SETUP) || (state_q == ST_RDS) || (state_q == ST_WRS) ||
                ((state_q == ST_HOLD) && !nop_q);

        if (ce_on) begin
            if (sel_q) begin
                XCE1s = 1'b0;
                CE2s  = 1'b1;
                XLB   = ~be_q[0];
                XUB   = ~be_q[1];
            end else begin
                XCEf  = 1'b0;
            end
            DQ_OE = wr_q;
        end

        case (state_q)
            ST_RSTP: XRESET    = 1'b0;
            ST_RDS:  XOE       = 1'b0;
            ST_WRS:  XWE       = 1'b0;
            ST_HOLD: RSP_VALID = (cnt_q == '0);
            default: ;
        endcase
    end

    assign REQ_READY  = ready;
    assign RSP_RDATA  = rdata_q;
    assign FLASH_BUSY = flash_busy;
    assign A          = addr_q;
    assign SA         = sa_q;
    assign DQ_O       = wdata_q;
    assign XWP        = 1'b1;
    assign CIOf       = 1'b1;
    assign CIOs       = 1'b1;

endmodule

// File: tb/tb_mcp_bus_initiator.sv
// Self-checking bench for mcp_bus_initiator: directed scenarios plus randomized
// requests scored against a cycle-count model of each access.
module tb_mcp_bus_initiator;

    localparam int AB = 20, W = 16;
    localparam int T_AS = 1, T_RD = 8, T_WP = 5, T_WH = 1, T_REC = 2, T_RST = 20;
    localparam int PERIOD = 10;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          REQ_VALID = 1'b0, REQ_WR = 1'b0, REQ_SEL = 1'b1, REQ_SA = 1'b0;
    logic [AB-1:0] REQ_ADDR = '0;
    logic [W-1:0]  REQ_WDATA = '0;
    logic [1:0]    REQ_BE = 2'b00;
    logic          RY_XBY = 1'b1;
    logic [W-1:0]  DQ_I;
    logic          REQ_READY, RSP_VALID, FLASH_BUSY, SA, DQ_OE;
    logic [W-1:0]  RSP_RDATA, DQ_O;
    logic [AB-1:0] A;
    logic          XCEf, XCE1s, CE2s, XOE, XWE, XLB, XUB, XRESET, XWP, CIOf, CIOs;

    always #(PERIOD/2) CLK = ~CLK;

    mcp_bus_initiator #(
        .AB(AB), .W(W), .T_AS(T_AS), .T_RD(T_RD), .T_WP(T_WP), .T_WH(T_WH),
        .T_REC(T_REC), .T_RST(T_RST), .WAIT_RDY(1)
    ) dut (
        .CLK(CLK), .RESET(RESET), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_WR(REQ_WR), .REQ_SEL(REQ_SEL), .REQ_ADDR(REQ_ADDR), .REQ_SA(REQ_SA),
        .REQ_WDATA(REQ_WDATA), .REQ_BE(REQ_BE), .RSP_VALID(RSP_VALID),
        .RSP_RDATA(RSP_RDATA), .FLASH_BUSY(FLASH_BUSY), .A(A), .SA(SA), .DQ_O(DQ_O),
        .DQ_OE(DQ_OE), .DQ_I(DQ_I), .XCEf(XCEf), .XCE1s(XCE1s), .CE2s(CE2s),
        .XOE(XOE), .XWE(XWE), .XLB(XLB), .XUB(XUB), .XRESET(XRESET), .XWP(XWP),
        .CIOf(CIOf), .CIOs(CIOs), .RY_XBY(RY_XBY)
    );

    int checks = 0;
    int errors = 0;

    // Die model: read data is only valid on the final cycle of the XOE pulse.
    logic [W-1:0] rd_val = '0;
    int oe_run = 0;
    int rsp_total = 0;
    int inv_viol = 0;
    logic [W-1:0] exp_rdata = '0;

    initial forever begin
        @(negedge CLK);
        if (XOE === 1'b0) oe_run++; else oe_run = 0;
        DQ_I = (XOE === 1'b0 && oe_run == T_RD) ? rd_val : ~rd_val;
        if (RSP_VALID === 1'b1) rsp_total++;
        ce_overlap: assert (!(XCEf === 1'b0 && XCE1s === 1'b0 && CE2s === 1'b1)) else inv_viol++;
        if (XOE === 1'b0 && XWE === 1'b0) inv_viol++;
        if (DQ_OE === 1'b1 && XOE === 1'b0) inv_viol++;
    end

    // Per-transaction measurements filled in by do_req.
    int  m_timeout, m_busy, m_lat, m_rsp, m_oe, m_we, m_dqoe, m_dq_after_we;
    int  m_cef, m_ces, m_first_ce, m_addr_bad, m_lane_bad, m_dq_bad;
    logic [W-1:0] m_rdata;
    time m_first_ce_t, m_last_ce_t;

    task automatic do_req(input logic wr, input logic sel, input logic [AB-1:0] addr,
                          input logic sa, input logic [W-1:0] wdata, input logic [1:0] be,
                          input logic [W-1:0] rdv);
        bit done = 0;
        bit prev_we = 0;
        bit cef, ces;
        int waitc = 0;
        rd_val = rdv;
        REQ_VALID = 1'b1; REQ_WR = wr; REQ_SEL = sel; REQ_ADDR = addr;
        REQ_SA = sa; REQ_WDATA = wdata; REQ_BE = be;
        m_timeout = 0; m_busy = 0; m_lat = 0; m_rsp = 0; m_oe = 0; m_we = 0; m_dqoe = 0;
        m_dq_after_we = 0; m_cef = 0; m_ces = 0; m_first_ce = 0; m_addr_bad = 0;
        m_lane_bad = 0; m_dq_bad = 0; m_rdata = 'x; m_first_ce_t = 0; m_last_ce_t = 0;
        #1;
        while (REQ_READY !== 1'b1 && waitc < 200) begin
            @(negedge CLK); #1; waitc++;
        end
        if (REQ_READY !== 1'b1) begin
            m_timeout = 1; REQ_VALID = 1'b0;
            return;
        end
        @(posedge CLK); #1;
        REQ_VALID = 1'b0; REQ_SEL = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge CLK);
            if (REQ_READY === 1'b1) begin done = 1; break; end
            m_busy++;
            if (RSP_VALID === 1'b1) begin
                m_rsp++;
                if (m_lat == 0) m_lat = k;
            end
            if (m_rsp == 1 && RSP_VALID === 1'b1) m_rdata = RSP_RDATA;
            cef = (XCEf === 1'b0);
            ces = (XCE1s === 1'b0 && CE2s === 1'b1);
            if (cef) m_cef++;
            if (ces) m_ces++;
            if (cef || ces) begin
                if (m_first_ce == 0) begin m_first_ce = k; m_first_ce_t = $time; end
                m_last_ce_t = $time;
                if (A !== addr || SA !== sa) m_addr_bad++;
                if ({XUB, XLB} !== (sel ? ~be : 2'b11)) m_lane_bad++;
            end
            if (XOE === 1'b0) m_oe++;
            if (XWE === 1'b0) m_we++;
            else if (prev_we) m_dq_after_we = (DQ_OE === 1'b1) ? 1 : 0;
            prev_we = (XWE === 1'b0);
            if (DQ_OE === 1'b1) begin
                m_dqoe++;
                if (DQ_O !== wdata) m_dq_bad++;
            end
        end
        if (!done) m_timeout = 1;
        $display("txn wr=%0d sel=%0d addr=%05h be=%b lat=%0d busy=%0d rdata=%04h",
                 wr, sel, addr, be, m_lat, m_busy, m_rdata);
    endtask

    task automatic test_reset();
        int low_cnt = 0;
        int ce_bad = 0;
        bit up = 0;
        RESET = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if ({XCEf, XCE1s, CE2s, XOE, XWE, XLB, XUB, XRESET, XWP, DQ_OE, REQ_READY, RSP_VALID}
            !== 12'b1101_1110_1000) begin
            errors++;
            $display("FAIL reset_pins: got %b, expected %b",
                {XCEf, XCE1s, CE2s, XOE, XWE, XLB, XUB, XRESET, XWP, DQ_OE, REQ_READY, RSP_VALID},
                12'b1101_1110_1000);
        end
        checks++;
        if ({A, DQ_O, RSP_RDATA} !== '0) begin
            errors++;
            $display("FAIL reset_regs: got A=%h DQ_O=%h RDATA=%h, expected all 0", A, DQ_O, RSP_RDATA);
        end
        checks++;
        if ({CIOf, CIOs, FLASH_BUSY} !== 3'b110) begin
            errors++;
            $display("FAIL reset_misc: got %b, expected 110", {CIOf, CIOs, FLASH_BUSY});
        end
        RESET = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge CLK);
            if (REQ_READY === 1'b1) begin up = 1; break; end
            if (XRESET === 1'b0) low_cnt++;
            if (XCEf !== 1'b1 || XCE1s !== 1'b1 || CE2s !== 1'b0) ce_bad++;
        end
        checks++;
        if (!up || XRESET !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: ready_seen=%0d XRESET=%b, expected 1 and 1", up, XRESET);
        end
        checks++;
        if (low_cnt != T_RST) begin
            errors++;
            $display("FAIL reset_xreset_len: got %0d cycles, expected %0d", low_cnt, T_RST);
        end
        checks++;
        if (ce_bad != 0) begin
            errors++;
            $display("FAIL reset_ce_idle: got %0d active-CE cycles, expected 0", ce_bad);
        end
        exp_rdata = '0;
    endtask

    task automatic test_flash_read();
        do_req(1'b0, 1'b0, 20'h12345, 1'b0, 16'h0000, 2'b11, 16'hA5C3);
        exp_rdata = 16'hA5C3;
        checks++;
        if (m_timeout != 0) begin errors++; $display("FAIL frd_timeout: got timeout, expected completion"); end
        checks++;
        if (m_first_ce != 1) begin errors++; $display("FAIL frd_ce_start: got cycle %0d, expected 1", m_first_ce); end
        checks++;
        if (m_oe != T_RD) begin errors++; $display("FAIL frd_xoe_len: got %0d, expected %0d", m_oe, T_RD); end
        checks++;
        if (m_lat != T_AS + T_RD + 1 || m_rsp != 1) begin
            errors++; $display("FAIL frd_latency: got lat=%0d pulses=%0d, expected lat=%0d pulses=1", m_lat, m_rsp, T_AS + T_RD + 1);
        end
        checks++;
        if (m_rdata !== 16'hA5C3) begin errors++; $display("FAIL frd_data: got %h, expected a5c3", m_rdata); end
        checks++;
        if (m_cef != T_AS + T_RD + T_WH || m_ces != 0 || m_dqoe != 0) begin
            errors++; $display("FAIL frd_ce: got cef=%0d ces=%0d dqoe=%0d, expected %0d 0 0", m_cef, m_ces, m_dqoe, T_AS + T_RD + T_WH);
        end
        checks++;
        if (m_addr_bad != 0 || m_lane_bad != 0) begin
            errors++; $display("FAIL frd_addr_lanes: got addr_bad=%0d lane_bad=%0d, expected 0 0", m_addr_bad, m_lane_bad);
        end
    endtask

    task automatic test_sram_write();
        do_req(1'b1, 1'b1, 20'h3FFFF, 1'b1, 16'hBEEF, 2'b10, 16'h0000);
        checks++;
        if (m_timeout != 0 || m_lat != T_AS + T_WP + 1) begin
            errors++; $display("FAIL swr_latency: got lat=%0d timeout=%0d, expected %0d 0", m_lat, m_timeout, T_AS + T_WP + 1);
        end
        checks++;
        if (m_ces != T_AS + T_WP + T_WH || m_cef != 0) begin
            errors++; $display("FAIL swr_ce: got ces=%0d cef=%0d, expected %0d 0", m_ces, m_cef, T_AS + T_WP + T_WH);
        end
        checks++;
        if (m_lane_bad != 0 || m_addr_bad != 0) begin
            errors++; $display("FAIL swr_lanes: got lane_bad=%0d addr_bad=%0d, expected 0 0", m_lane_bad, m_addr_bad);
        end
        checks++;
        if (m_we != T_WP || m_oe != 0) begin
            errors++; $display("FAIL swr_xwe_len: got we=%0d oe=%0d, expected %0d 0", m_we, m_oe, T_WP);
        end
        checks++;
        if (m_dq_after_we != 1 || m_dqoe != T_AS + T_WP + T_WH || m_dq_bad != 0) begin
            errors++; $display("FAIL swr_dq_oe: got after_we=%0d oe_cycles=%0d dq_bad=%0d, expected 1 %0d 0",
                               m_dq_after_we, m_dqoe, m_dq_bad, T_AS + T_WP + T_WH);
        end
        checks++;
        if (RSP_RDATA !== exp_rdata) begin
            errors++; $display("FAIL swr_rdata_held: got %h, expected %h", RSP_RDATA, exp_rdata);
        end
    endtask

    task automatic test_sram_nop();
        do_req(1'b1, 1'b1, 20'h00010, 1'b0, 16'h5555, 2'b00, 16'h0000);
        checks++;
        if (m_timeout != 0 || m_lat != 1 || m_rsp != 1) begin
            errors++; $display("FAIL nop_latency: got lat=%0d pulses=%0d, expected 1 1", m_lat, m_rsp);
        end
        checks++;
        if (m_we != 0 || m_ces != 0 || m_dqoe != 0 || m_busy != 1 + T_REC) begin
            errors++; $display("FAIL nop_pins: got we=%0d ces=%0d dqoe=%0d busy=%0d, expected 0 0 0 %0d",
                               m_we, m_ces, m_dqoe, m_busy, 1 + T_REC);
        end
    endtask

    task automatic test_back_to_back();
        time t_end_first;
        int gap;
        do_req(1'b0, 1'b0, 20'h0ABCD, 1'b0, 16'h0000, 2'b11, 16'h1357);
        t_end_first = m_last_ce_t;
        do_req(1'b0, 1'b1, 20'h01234, 1'b1, 16'h0000, 2'b11, 16'h2468);
        exp_rdata = 16'h2468;
        gap = int'((m_first_ce_t - t_end_first) / PERIOD) - 1;
        checks++;
        if (m_timeout != 0 || gap < T_REC) begin
            errors++; $display("FAIL b2b_gap: got %0d idle cycles (timeout=%0d), expected >= %0d", gap, m_timeout, T_REC);
        end
        checks++;
        if (m_rdata !== 16'h2468) begin errors++; $display("FAIL b2b_data: got %h, expected 2468", m_rdata); end
        checks++;
        if (inv_viol != 0) begin errors++; $display("FAIL b2b_invariants: got %0d violations, expected 0", inv_viol); end
    endtask

    task automatic test_wait_rdy();
        int stall_bad = 0;
        int k = 0;
        RY_XBY = 1'b0;
        repeat (3) @(negedge CLK);
        checks++;
        if (FLASH_BUSY !== 1'b1) begin errors++; $display("FAIL wr_busy_sync: got %b, expected 1", FLASH_BUSY); end
        REQ_VALID = 1'b1; REQ_SEL = 1'b0; REQ_WR = 1'b0; REQ_ADDR = 20'h00F00;
        repeat (6) begin
            @(negedge CLK);
            if (REQ_READY !== 1'b0) stall_bad++;
        end
        REQ_VALID = 1'b0;
        checks++;
        if (stall_bad != 0) begin errors++; $display("FAIL wr_flash_stall: got %0d ready cycles, expected 0", stall_bad); end
        do_req(1'b0, 1'b1, 20'h00222, 1'b0, 16'h0000, 2'b11, 16'h7E7E);
        exp_rdata = 16'h7E7E;
        checks++;
        if (m_timeout != 0 || m_rdata !== 16'h7E7E) begin
            errors++; $display("FAIL wr_sram_proceeds: got data=%h timeout=%0d, expected 7e7e 0", m_rdata, m_timeout);
        end
        REQ_VALID = 1'b1; REQ_SEL = 1'b0; REQ_WR = 1'b0; REQ_ADDR = 20'h00F00;
        @(posedge CLK); #1;
        RY_XBY = 1'b1;
        while (k < 10) begin
            @(negedge CLK); k++;
            if (REQ_READY === 1'b1) break;
        end
        checks++;
        if (k < 2 || k > 3) begin errors++; $display("FAIL wr_release_delay: got %0d cycles, expected 2..3", k); end
        do_req(1'b0, 1'b0, 20'h00F00, 1'b0, 16'h0000, 2'b11, 16'hC001);
        exp_rdata = 16'hC001;
        checks++;
        if (m_timeout != 0 || m_rdata !== 16'hC001) begin
            errors++; $display("FAIL wr_flash_after_ready: got data=%h timeout=%0d, expected c001 0", m_rdata, m_timeout);
        end
    endtask

    task automatic test_reset_during_write();
        int rsp0 = rsp_total;
        bit seen = 0;
        bit up = 0;
        REQ_VALID = 1'b1; REQ_WR = 1'b1; REQ_SEL = 1'b1; REQ_ADDR = 20'h00ABC;
        REQ_SA = 1'b0; REQ_WDATA = 16'h1234; REQ_BE = 2'b11;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (REQ_READY === 1'b1) break;
            @(negedge CLK);
        end
        @(posedge CLK); #1;
        REQ_VALID = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            if (XWE === 1'b0) begin seen = 1; break; end
        end
        @(negedge CLK);
        RESET = 1'b1;
        @(posedge CLK); #1;
        checks++;
        if (!seen || {XWE, DQ_OE, XCE1s, CE2s, XRESET} !== 5'b10100) begin
            errors++; $display("FAIL rst_wrs_pins: got we_seen=%0d pins=%b, expected 1 10100",
                               seen, {XWE, DQ_OE, XCE1s, CE2s, XRESET});
        end
        checks++;
        if (A !== '0) begin errors++; $display("FAIL rst_wrs_addr: got %h, expected 0", A); end
        @(posedge CLK); #1;
        RESET = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge CLK);
            if (REQ_READY === 1'b1) begin up = 1; break; end
        end
        exp_rdata = '0;
        checks++;
        if (!up || rsp_total != rsp0) begin
            errors++; $display("FAIL rst_wrs_no_rsp: got ready=%0d responses=%0d, expected 1 0", up, rsp_total - rsp0);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            logic wr, sel, sa, nop;
            logic [AB-1:0] addr;
            logic [1:0] be;
            logic [W-1:0] wdata, rdv;
            int strobe, exp_lat, exp_busy, exp_ce;
            wr = 1'($urandom_range(0, 1));
            sel = 1'($urandom_range(0, 1));
            sa = 1'($urandom_range(0, 1));
            be = 2'($urandom_range(0, 3));
            addr = AB'($urandom);
            if (sel) addr = addr & 20'h3FFFF;
            wdata = W'($urandom);
            rdv = W'($urandom);
            do_req(wr, sel, addr, sa, wdata, be, rdv);
            nop = sel && wr && (be == 2'b00);
            strobe = wr ? T_WP : T_RD;
            exp_lat = nop ? 1 : T_AS + strobe + 1;
            exp_busy = nop ? 1 + T_REC : T_AS + strobe + T_WH + T_REC;
            exp_ce = nop ? 0 : T_AS + strobe + T_WH;
            if (!wr) exp_rdata = rdv;
            checks++;
            if (m_timeout != 0 || m_lat != exp_lat || m_rsp != 1 || m_busy != exp_busy) begin
                errors++; $display("FAIL rnd%0d_timing: got lat=%0d rsp=%0d busy=%0d, expected %0d 1 %0d",
                                   n, m_lat, m_rsp, m_busy, exp_lat, exp_busy);
            end
            checks++;
            if (m_rdata !== exp_rdata) begin
                errors++; $display("FAIL rnd%0d_rdata: got %h, expected %h", n, m_rdata, exp_rdata);
            end
            checks++;
            if ((sel ? m_ces : m_cef) != exp_ce || (sel ? m_cef : m_ces) != 0) begin
                errors++; $display("FAIL rnd%0d_ce: got cef=%0d ces=%0d, expected %0d on sel=%0d", n, m_cef, m_ces, exp_ce, sel);
            end
            checks++;
            if (m_oe != (wr ? 0 : T_RD) || m_we != ((wr && !nop) ? T_WP : 0) ||
                m_dqoe != ((wr && !nop) ? T_AS + T_WP + T_WH : 0)) begin
                errors++; $display("FAIL rnd%0d_strobes: got oe=%0d we=%0d dqoe=%0d", n, m_oe, m_we, m_dqoe);
            end
            checks++;
            if (m_addr_bad != 0 || m_lane_bad != 0 || m_dq_bad != 0) begin
                errors++; $display("FAIL rnd%0d_bus: got addr_bad=%0d lane_bad=%0d dq_bad=%0d, expected 0 0 0",
                                   n, m_addr_bad, m_lane_bad, m_dq_bad);
            end
        end
    endtask

    initial begin
        test_reset();
        test_flash_read();
        test_sram_write();
        test_sram_nop();
        test_back_to_back();
        test_wait_rdy();
        test_reset_during_write();
        test_random();
        checks++;
        if (inv_viol != 0) begin
            errors++; $display("FAIL invariants: got %0d violations, expected 0", inv_viol);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #(PERIOD * 20000);
        $display("FAIL watchdog: simulation did not finish within %0d cycles", 20000);
        $fatal(1);
    end

endmodule
